// File: rtl/fma16_pkg.sv
// Shared types and constants for the fp16 FMA addend-alignment stage.
// Optional build macro used by fma16_align_stage: FMA16_ALIGN_PIPE2_EN.
package fma16_pkg;

    localparam int NF       = 10;
    localparam int BIAS     = 15;
    localparam int AW       = 4*NF + 6;
    localparam int ACNTW    = 8;
    localparam int ACNT_OFS = NF + 3;
    localparam int KILLZ_MAX = AW - NF - 1;

    typedef struct packed {
        logic [6:0]  Pe;
        logic        PZero;
        logic        PSgn;
        logic [4:0]  Ze;
        logic [NF:0] Zm;
        logic        ZSgn;
    } align_in_t;

    typedef struct packed {
        logic [AW-1:0] Am;
        logic          ASticky;
        logic          KillProd;
        logic          InvA;
        logic [6:0]    ExpOut;
    } align_out_t;

    // Pe is signed and may be below zero for tiny products; Ze is always unsigned.
    function automatic logic signed [ACNTW-1:0] calc_acnt(input logic [6:0] pe,
                                                          input logic [4:0] ze);
        return $signed({pe[6], pe}) - $signed({3'b000, ze}) + 8'sd13;
    endfunction

endpackage

// File: rtl/fma16_align_core.sv
// Combinational alignment of the Z significand against the product exponent.
// Shared by both pipeline depths of fma16_align_stage (FMA16_ALIGN_PIPE2_EN).
import fma16_pkg::*;

module fma16_align_core (
    input  align_in_t               i_beat,
    input  logic signed [ACNTW-1:0] i_acnt,
    output align_out_t              o_res
);

    logic          w_kill_p;
    logic          w_kill_z;
    logic [AW-1:0] w_field;
    logic [AW-1:0] w_shifted;

    assign w_kill_p  = i_beat.PZero | (i_acnt < 8'sd0);
    assign w_kill_z  = (i_acnt > 8'sd35);
    assign w_field   = {i_beat.Zm, {KILLZ_MAX{1'b0}}};
    assign w_shifted = w_field >> i_acnt[5:0];

    always_comb begin
        o_res      = '0;
        o_res.InvA = i_beat.PSgn ^ i_beat.ZSgn;
        if (w_kill_p) begin
            // Product contributes nothing: park Z at the product-sized position.
            o_res.KillProd = 1'b1;
            o_res.Am       = {12'b0, i_beat.Zm, 23'b0};
            o_res.ExpOut   = {2'b00, i_beat.Ze};
        end else if (w_kill_z) begin
            o_res.ASticky  = |i_beat.Zm;
            o_res.ExpOut   = i_beat.Pe;
        end else begin
            o_res.Am       = w_shifted;
            o_res.ExpOut   = i_beat.Pe;
        end
    end

endmodule

// File: rtl/fma16_align_stage.sv
// Addend-alignment pipeline stage: valid/ready handshake, output register plus skid buffer.
// FMA16_ALIGN_PIPE2_EN adds a register between Acnt compute and the shifter (latency 2, skid 2).
import fma16_pkg::*;

module fma16_align_stage (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [6:0]    Pe,
    input  logic          PZero,
    input  logic          PSgn,
    input  logic [4:0]    Ze,
    input  logic [10:0]   Zm,
    input  logic          ZSgn,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [45:0]   Am,
    output logic          ASticky,
    output logic          KillProd,
    output logic          InvA,
    output logic [6:0]    ExpOut
);

    align_in_t  w_in_beat;
    align_out_t w_res;
    logic       w_in_fire;
    logic       w_src_v;
    logic       r_in_ready;

    assign w_in_beat = '{Pe: Pe, PZero: PZero, PSgn: PSgn, Ze: Ze, Zm: Zm, ZSgn: ZSgn};
    assign w_in_fire = InValid & r_in_ready;

`ifdef FMA16_ALIGN_PIPE2_EN
    localparam int SKD = 2;

    logic                    r_a_v;
    align_in_t               r_a_beat;
    logic signed [ACNTW-1:0] r_a_acnt;

    // Stage A never stalls; the credit check on InReady guarantees skid room downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_v    <= 1'b0;
            r_a_beat <= '0;
            r_a_acnt <= '0;
        end else begin
            r_a_v <= w_in_fire;
            if (w_in_fire) begin
                r_a_beat <= w_in_beat;
                r_a_acnt <= calc_acnt(Pe, Ze);
            end
        end
    end

    fma16_align_core u_core (
        .i_beat (r_a_beat),
        .i_acnt (r_a_acnt),
        .o_res  (w_res)
    );

    assign w_src_v = r_a_v;
`else
    localparam int SKD = 1;

    logic signed [ACNTW-1:0] w_acnt;

    assign w_acnt = calc_acnt(Pe, Ze);

    fma16_align_core u_core (
        .i_beat (w_in_beat),
        .i_acnt (w_acnt),
        .o_res  (w_res)
    );

    assign w_src_v = w_in_fire;
`endif

    align_out_t r_out;
    logic       r_out_v;
    align_out_t r_skid   [SKD];
    align_out_t w_skid_n [SKD];
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_n;
    logic [1:0] w_pos;
    logic       w_load;
    logic       w_pop;
    logic       w_push;
    align_out_t w_out_n;
    logic       w_out_v_n;

    assign w_load = ~r_out_v | OutReady;
    assign w_pop  = w_load & (r_cnt != 2'd0);
    assign w_push = w_src_v & ~(w_load & (r_cnt == 2'd0));
    assign w_pos  = r_cnt - {1'b0, w_pop};

    // Oldest skid entry always sits at index 0 so ordering is preserved.
    always_comb begin
        w_skid_n  = r_skid;
        w_out_n   = r_out;
        w_out_v_n = r_out_v;
        w_cnt_n   = r_cnt - {1'b0, w_pop} + {1'b0, w_push};
        if (w_pop) begin
            for (int i = 0; i < SKD - 1; i++) begin
                w_skid_n[i] = r_skid[i+1];
            end
        end
        if (w_push) begin
            for (int i = 0; i < SKD; i++) begin
                if (i == int'(w_pos)) begin
                    w_skid_n[i] = w_res;
                end
            end
        end
        if (w_load) begin
            if (w_pop) begin
                w_out_n   = r_skid[0];
                w_out_v_n = 1'b1;
            end else if (w_src_v) begin
                w_out_n   = w_res;
                w_out_v_n = 1'b1;
            end else begin
                w_out_v_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out      <= '0;
            r_out_v    <= 1'b0;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < SKD; i++) begin
                r_skid[i] <= '0;
            end
        end else begin
            r_out   <= w_out_n;
            r_out_v <= w_out_v_n;
            r_cnt   <= w_cnt_n;
            r_skid  <= w_skid_n;
`ifdef FMA16_ALIGN_PIPE2_EN
            r_in_ready <= ({1'b0, w_cnt_n} + {2'b00, w_in_fire}) < 3'd2;
`else
            r_in_ready <= (w_cnt_n == 2'd0);
`endif
        end
    end

    assign InReady  = r_in_ready;
    assign OutValid = r_out_v;
    assign Am       = r_out.Am;
    assign ASticky  = r_out.ASticky;
    assign KillProd = r_out.KillProd;
    assign InvA     = r_out.InvA;
    assign ExpOut   = r_out.ExpOut;

endmodule

// File: tb/tb_fma16_align_stage.sv
// Self-checking bench for fma16_align_stage: directed cases, random traffic against a
// queue-based reference model, stall/skid behaviour and mid-stream reset.
module tb_fma16_align_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        InValid;
    logic        InReady;
    logic [6:0]  Pe;
    logic        PZero;
    logic        PSgn;
    logic [4:0]  Ze;
    logic [10:0] Zm;
    logic        ZSgn;
    logic        OutValid;
    logic        OutReady;
    logic [45:0] Am;
    logic        ASticky;
    logic        KillProd;
    logic        InvA;
    logic [6:0]  ExpOut;

    always #5 clk = ~clk;

    fma16_align_stage dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .Pe       (Pe),
        .PZero    (PZero),
        .PSgn     (PSgn),
        .Ze       (Ze),
        .Zm       (Zm),
        .ZSgn     (ZSgn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Am       (Am),
        .ASticky  (ASticky),
        .KillProd (KillProd),
        .InvA     (InvA),
        .ExpOut   (ExpOut)
    );

    int          checks = 0;
    int          errors = 0;
    logic [55:0] q[$];
    logic        hold_prev = 1'b0;
    logic [55:0] held;
    logic        last_in_fire;
    logic [55:0] dut_out;

    assign dut_out = {Am, ASticky, KillProd, InvA, ExpOut};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: alignment count as a plain integer, Z placed by multiplying by a power of two.
    function automatic logic [55:0] ref_out(input logic [6:0] pe, input logic pz, input logic ps,
                                            input logic [4:0] ze, input logic [10:0] zm,
                                            input logic zs);
        int          pe_i;
        int          acnt;
        longint      am;
        logic        st;
        logic        kp;
        logic [6:0]  eo;
        pe_i = pe[6] ? int'(pe) - 128 : int'(pe);
        acnt = pe_i - int'(ze) + 13;
        st   = 1'b0;
        if (pz || acnt < 0) begin
            kp = 1'b1;
            am = longint'(zm) * (64'd1 << 23);
            eo = {2'b00, ze};
        end else if (acnt > 35) begin
            kp = 1'b0;
            am = 0;
            st = (zm != 0);
            eo = pe;
        end else begin
            kp = 1'b0;
            am = longint'(zm) * (64'd1 << (35 - acnt));
            eo = pe;
        end
        return {am[45:0], st, kp, ps ^ zs, eo};
    endfunction

    task automatic set_beat(input logic [6:0] pe, input logic pz, input logic ps,
                            input logic [4:0] ze, input logic [10:0] zm, input logic zs);
        Pe = pe; PZero = pz; PSgn = ps; Ze = ze; Zm = zm; ZSgn = zs;
    endtask

    task automatic rand_beat();
        logic [10:0] zm;
        zm = ($urandom_range(0, 7) == 0) ? 11'h000 : {1'b1, 10'($urandom)};
        set_beat(7'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                 5'($urandom), zm, 1'($urandom));
    endtask

    // Called just after a negedge with inputs driven; books the upcoming edge.
    task automatic tick();
        logic in_f;
        logic out_f;
        in_f  = InValid && InReady;
        out_f = OutValid && OutReady;
        chk("ready_vs_occupancy", InReady, (q.size() < 2));
        chk("valid_vs_occupancy", OutValid, (q.size() != 0));
        if (hold_prev) chk("held_stable", dut_out, held);
        if (out_f && q.size() != 0) begin
            chk("out_beat", dut_out, q[0]);
            void'(q.pop_front());
        end
        hold_prev = OutValid && !OutReady;
        held      = dut_out;
        if (in_f) q.push_back(ref_out(Pe, PZero, PSgn, Ze, Zm, ZSgn));
        last_in_fire = in_f;
        @(negedge clk);
    endtask

    task automatic drain();
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain_empty", q.size(), 0);
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        set_beat(7'd0, 1'b0, 1'b0, 5'd0, 11'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_inready", InReady, 1);
        chk("rst_data", dut_out, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Case 1: nominal alignment, Acnt = 13.
        OutReady = 1'b1;
        InValid  = 1'b1;
        set_beat(7'd15, 1'b0, 1'b0, 5'd15, 11'h400, 1'b0);
        tick();
        InValid = 1'b0;
        chk("t1_valid", OutValid, 1);
        chk("t1_am", Am, 46'h400 << 22);
        chk("t1_kill", KillProd, 0);
        chk("t1_exp", ExpOut, 15);
        tick();

        // Case 2: Acnt = -17 kills the product.
        InValid = 1'b1;
        set_beat(7'd0, 1'b0, 1'b0, 5'd30, 11'h7FF, 1'b0);
        tick();
        InValid = 1'b0;
        chk("t2_kill", KillProd, 1);
        chk("t2_am", Am, {12'b0, 11'h7FF, 23'b0});
        chk("t2_exp", ExpOut, 30);
        tick();

        // Case 3: Acnt = 57, Z shifted out entirely.
        InValid = 1'b1;
        set_beat(7'd45, 1'b0, 1'b0, 5'd1, 11'h401, 1'b0);
        tick();
        InValid = 1'b0;
        chk("t3_am", Am, 0);
        chk("t3_sticky", ASticky, 1);
        chk("t3_kill", KillProd, 0);
        chk("t3_exp", ExpOut, 45);
        tick();

        // Case 5: zero product with effective subtraction.
        InValid = 1'b1;
        set_beat(7'd0, 1'b1, 1'b1, 5'd10, 11'h5A5, 1'b0);
        tick();
        InValid = 1'b0;
        chk("t5_kill", KillProd, 1);
        chk("t5_inva", InvA, 1);
        chk("t5_exp", ExpOut, 10);
        tick();

        // Case 4: four beats with the output stalled after the first.
        InValid = 1'b1;
        set_beat(7'd20, 1'b0, 1'b0, 5'd12, 11'h401, 1'b0);
        tick();
        OutReady = 1'b0;
        set_beat(7'd21, 1'b0, 1'b1, 5'd12, 11'h402, 1'b0);
        tick();
        chk("t4_inready_low", InReady, 0);
        chk("t4_outvalid", OutValid, 1);
        set_beat(7'd22, 1'b0, 1'b0, 5'd12, 11'h403, 1'b1);
        tick();
        chk("t4_still_blocked", InReady, 0);
        OutReady = 1'b1;
        last_in_fire = 1'b0;
        for (int i = 0; i < 8 && !last_in_fire; i++) tick();
        chk("t4_beat3_accept", last_in_fire, 1);
        set_beat(7'd23, 1'b0, 1'b1, 5'd12, 11'h404, 1'b1);
        last_in_fire = 1'b0;
        for (int i = 0; i < 8 && !last_in_fire; i++) tick();
        chk("t4_beat4_accept", last_in_fire, 1);
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            rand_beat();
            tick();
        end
        drain();

        // Case 6: reset with the skid full.
        OutReady = 1'b0;
        InValid  = 1'b1;
        rand_beat();
        tick();
        rand_beat();
        tick();
        InValid = 1'b0;
        chk("t6_skid_full", InReady, 0);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_outvalid", OutValid, 0);
        chk("t6_rst_inready", InReady, 1);
        chk("t6_rst_data", dut_out, 0);
        q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        OutReady = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_no_stale", OutValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
